// File: rtl/track_pkg.sv
`default_nettype none
// ============================================================================
// track_pkg : track geometry, coordinate width and tracker FSM state type
// Revision  : 1.0
// ============================================================================
package track_pkg;

   localparam int COORD_W = 11;
   localparam int MAX_CP  = 16;
   localparam int IDX_W   = 5;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t x0;
      coord_t x1;
      coord_t y0;
      coord_t y1;
   } region_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam region_t FINISH_REGION = '{x0: 11'd506, x1: 11'd529, y0: 11'd0, y1: 11'd160};
   // Inverted bounds: no well-formed bounding box can ever satisfy this region.
   localparam region_t NO_REGION     = '{x0: 11'h7FF, x1: 11'd0, y0: 11'h7FF, y1: 11'd0};

   function automatic region_t cp_region(input logic [IDX_W-1:0] idx);
      case (idx)
         5'd0:    cp_region = '{x0: 11'd790, x1: 11'd912,  y0: 11'd190, y1: 11'd215};
         5'd1:    cp_region = '{x0: 11'd735, x1: 11'd760,  y0: 11'd246, y1: 11'd450};
         5'd2:    cp_region = '{x0: 11'd538, x1: 11'd565,  y0: 11'd304, y1: 11'd512};
         5'd3:    cp_region = '{x0: 11'd136, x1: 11'd268,  y0: 11'd442, y1: 11'd470};
         5'd4:    cp_region = '{x0: 11'd824, x1: 11'd1008, y0: 11'd628, y1: 11'd655};
         5'd5:    cp_region = '{x0: 11'd48,  x1: 11'd186,  y0: 11'd424, y1: 11'd450};
         default: cp_region = NO_REGION;
      endcase
   endfunction

   function automatic logic [IDX_W-1:0] popcount(input logic [MAX_CP-1:0] v);
      logic [IDX_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_CP; i++) begin
         n = n + IDX_W'(v[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/track_regions.sv
`default_nettype none
// ============================================================================
// track_regions : combinational lookup of region bounds by scan index
// Revision      : 1.0
// ============================================================================
module track_regions
   import track_pkg::*;
#(
   parameter int NUM_CP = 6
) (
   input  logic [IDX_W-1:0]   idx,
   output logic [COORD_W-1:0] x0,
   output logic [COORD_W-1:0] x1,
   output logic [COORD_W-1:0] y0,
   output logic [COORD_W-1:0] y1
);

   region_t region;

   // Index NUM_CP follows the last checkpoint and selects the finish line.
   always_comb begin
      region = NO_REGION;
      if (idx == IDX_W'(NUM_CP)) begin
         region = FINISH_REGION;
      end else if (idx < IDX_W'(NUM_CP)) begin
         region = cp_region(idx);
      end
   end

   assign x0 = region.x0;
   assign x1 = region.x1;
   assign y0 = region.y0;
   assign y1 = region.y1;

endmodule
`default_nettype wire

// File: rtl/lap_tracker.sv
`default_nettype none
// ============================================================================
// lap_tracker : per-frame checkpoint/finish scanner with lap timing
// Revision    : 1.0
// ============================================================================
module lap_tracker
   import track_pkg::*;
#(
   parameter int NUM_CP  = 6,
   parameter int ORDERED = 0,
   parameter int LAPS    = 3,
   parameter int TIME_W  = 16
) (
   input  logic                       pclk,
   input  logic                       rst,
   input  logic                       frame_tick,
   input  logic [COORD_W-1:0]         car_x_start,
   input  logic [COORD_W-1:0]         car_x_end,
   input  logic [COORD_W-1:0]         car_y_start,
   input  logic [COORD_W-1:0]         car_y_end,
   output logic [NUM_CP-1:0]          cp_mask,
   output logic                       checkpoints_passed,
   output logic                       lap_finished,
   output logic [$clog2(LAPS+1)-1:0]  lap_count,
   output logic [TIME_W-1:0]          lap_time,
   output logic [TIME_W-1:0]          best_lap,
   output logic                       race_done
);

   localparam int                CNT_W    = $clog2(LAPS + 1);
   localparam logic [CNT_W-1:0]  LAPS_CNT = CNT_W'(LAPS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CP);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [COORD_W-1:0]   x_start_q, x_start_d, x_end_q, x_end_d;
   logic [COORD_W-1:0]   y_start_q, y_start_d, y_end_q, y_end_d;
   logic [NUM_CP-1:0]    work_mask_q, work_mask_d;
   logic                 fin_hit_q, fin_hit_d;
   logic                 prev_fin_q, prev_fin_d;
   logic [NUM_CP-1:0]    cp_mask_q, cp_mask_d;
   logic                 lap_finished_q, lap_finished_d;
   logic [CNT_W-1:0]     lap_count_q, lap_count_d;
   logic [TIME_W-1:0]    lap_time_q, lap_time_d;
   logic [TIME_W-1:0]    best_lap_q, best_lap_d;
   logic [TIME_W-1:0]    timer_q, timer_d;
   logic                 race_done_q, race_done_d;

   logic [COORD_W-1:0]   reg_x0, reg_x1, reg_y0, reg_y1;
   logic                 region_hit;
   logic                 in_order;
   logic [NUM_CP-1:0]    cp_sel;

   track_regions #(.NUM_CP(NUM_CP)) u_regions (
      .idx (idx_q),
      .x0  (reg_x0),
      .x1  (reg_x1),
      .y0  (reg_y0),
      .y1  (reg_y1)
   );

   assign region_hit = (x_start_q >= reg_x0) && (x_end_q <= reg_x1) &&
                       (y_start_q >= reg_y0) && (y_end_q <= reg_y1);

   // Working mask is filled in index order, so its popcount is the next expected checkpoint.
   assign in_order = (idx_q == popcount(MAX_CP'(work_mask_q)));

   always_comb begin
      for (int i = 0; i < NUM_CP; i++) begin
         cp_sel[i] = (idx_q == IDX_W'(i));
      end
   end

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      x_start_d      = x_start_q;
      x_end_d        = x_end_q;
      y_start_d      = y_start_q;
      y_end_d        = y_end_q;
      work_mask_d    = work_mask_q;
      fin_hit_d      = fin_hit_q;
      prev_fin_d     = prev_fin_q;
      cp_mask_d      = cp_mask_q;
      lap_finished_d = 1'b0;
      lap_count_d    = lap_count_q;
      lap_time_d     = lap_time_q;
      best_lap_d     = best_lap_q;
      timer_d        = timer_q;
      race_done_d    = race_done_q;

      if (frame_tick && !race_done_q && (timer_q != '1)) begin
         timer_d = timer_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               x_start_d   = car_x_start;
               x_end_d     = car_x_end;
               y_start_d   = car_y_start;
               y_end_d     = car_y_end;
               idx_d       = '0;
               work_mask_d = cp_mask_q;
               fin_hit_d   = 1'b0;
               state_d     = SCAN;
            end
         end
         SCAN: begin
            if (idx_q == LAST_IDX) begin
               fin_hit_d = region_hit;
               state_d   = COMMIT;
            end else begin
               if (region_hit && ((ORDERED == 0) || in_order)) begin
                  work_mask_d = work_mask_q | cp_sel;
               end
               idx_d = idx_q + 1'b1;
            end
         end
         COMMIT: begin
            state_d    = IDLE;
            prev_fin_d = fin_hit_q;
            cp_mask_d  = work_mask_q;
            if (fin_hit_q && !prev_fin_q && (&work_mask_q) && !race_done_q) begin
               lap_finished_d = 1'b1;
               lap_count_d    = lap_count_q + 1'b1;
               lap_time_d     = timer_q;
               best_lap_d     = (timer_q < best_lap_q) ? timer_q : best_lap_q;
               cp_mask_d      = '0;
               timer_d        = frame_tick ? TIME_W'(1) : '0;
               if ((lap_count_q + 1'b1) == LAPS_CNT) begin
                  race_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         x_start_q      <= '0;
         x_end_q        <= '0;
         y_start_q      <= '0;
         y_end_q        <= '0;
         work_mask_q    <= '0;
         fin_hit_q      <= 1'b0;
         prev_fin_q     <= 1'b0;
         cp_mask_q      <= '0;
         lap_finished_q <= 1'b0;
         lap_count_q    <= '0;
         lap_time_q     <= '0;
         best_lap_q     <= '1;
         timer_q        <= '0;
         race_done_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         x_start_q      <= x_start_d;
         x_end_q        <= x_end_d;
         y_start_q      <= y_start_d;
         y_end_q        <= y_end_d;
         work_mask_q    <= work_mask_d;
         fin_hit_q      <= fin_hit_d;
         prev_fin_q     <= prev_fin_d;
         cp_mask_q      <= cp_mask_d;
         lap_finished_q <= lap_finished_d;
         lap_count_q    <= lap_count_d;
         lap_time_q     <= lap_time_d;
         best_lap_q     <= best_lap_d;
         timer_q        <= timer_d;
         race_done_q    <= race_done_d;
      end
   end

   assign cp_mask            = cp_mask_q;
   assign checkpoints_passed = &cp_mask_q;
   assign lap_finished       = lap_finished_q;
   assign lap_count          = lap_count_q;
   assign lap_time           = lap_time_q;
   assign best_lap           = best_lap_q;
   assign race_done          = race_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lap_tracker.sv
`default_nettype none
// ============================================================================
// tb_lap_tracker : randomized bench for lap_tracker (unordered and ordered)
// Revision       : 1.0
// ============================================================================
module tb_lap_tracker;

   logic        pclk = 1'b0;
   logic        rst = 1'b0;
   logic        frame_tick = 1'b0;
   logic [10:0] bx0 = '0, bx1 = '0, by0 = '0, by1 = '0;

   logic [5:0]  cp_mask_u, cp_mask_o;
   logic        cpp_u, cpp_o, lf_u, lf_o, rd_u, rd_o;
   logic [1:0]  lc_u, lc_o;
   logic [15:0] lt_u, lt_o, bl_u, bl_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 pclk = ~pclk;

   lap_tracker #(.NUM_CP(6), .ORDERED(0), .LAPS(3), .TIME_W(16)) dut_u (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick),
      .car_x_start(bx0), .car_x_end(bx1), .car_y_start(by0), .car_y_end(by1),
      .cp_mask(cp_mask_u), .checkpoints_passed(cpp_u), .lap_finished(lf_u),
      .lap_count(lc_u), .lap_time(lt_u), .best_lap(bl_u), .race_done(rd_u)
   );

   lap_tracker #(.NUM_CP(6), .ORDERED(1), .LAPS(3), .TIME_W(16)) dut_o (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick),
      .car_x_start(bx0), .car_x_end(bx1), .car_y_start(by0), .car_y_end(by1),
      .cp_mask(cp_mask_o), .checkpoints_passed(cpp_o), .lap_finished(lf_o),
      .lap_count(lc_o), .lap_time(lt_o), .best_lap(bl_o), .race_done(rd_o)
   );

   // Track table: entries 0..5 are checkpoints, entry 6 is the finish line.
   int rx0[7] = '{790, 735, 538, 136, 824,  48, 506};
   int rx1[7] = '{912, 760, 565, 268, 1008, 186, 529};
   int ry0[7] = '{190, 246, 304, 442, 628, 424,   0};
   int ry1[7] = '{215, 450, 512, 470, 655, 450, 160};

   // Reference state, index 0 = any-order tracker, 1 = strict-order tracker.
   bit [5:0] m_mask[2];
   bit       m_prev[2];
   int       m_cnt[2], m_time[2], m_best[2], m_timer[2];
   bit       m_done[2], m_pulse[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mask[k] = '0; m_prev[k] = 0; m_cnt[k] = 0; m_time[k] = 0;
         m_best[k] = 16'hFFFF; m_timer[k] = 0; m_done[k] = 0; m_pulse[k] = 0;
      end
   endtask

   task automatic model_tick();
      for (int k = 0; k < 2; k++)
         if (!m_done[k] && m_timer[k] < 65535) m_timer[k]++;
   endtask

   function automatic bit inside_reg(int r, int xs, int xe, int ys, int ye);
      return (xs >= rx0[r]) && (xe <= rx1[r]) && (ys >= ry0[r]) && (ye <= ry1[r]);
   endfunction

   task automatic model_eval(input int xs, input int xe, input int ys, input int ye);
      bit fin;
      fin = inside_reg(6, xs, xe, ys, ye);
      for (int k = 0; k < 2; k++) begin
         m_pulse[k] = 0;
         for (int i = 0; i < 6; i++) begin
            if (inside_reg(i, xs, xe, ys, ye) && (k == 0 || i == $countones(m_mask[k])))
               m_mask[k][i] = 1'b1;
         end
         if (fin && !m_prev[k] && m_mask[k] == 6'h3F && !m_done[k]) begin
            m_pulse[k] = 1;
            m_cnt[k]++;
            m_time[k] = m_timer[k];
            if (m_timer[k] < m_best[k]) m_best[k] = m_timer[k];
            m_mask[k] = '0;
            m_timer[k] = 0;
            if (m_cnt[k] == 3) m_done[k] = 1;
         end
         m_prev[k] = fin;
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, " mask_u"}, 32'(cp_mask_u), 32'(m_mask[0]));
      check_eq({tag, " mask_o"}, 32'(cp_mask_o), 32'(m_mask[1]));
      check_eq({tag, " cpp_u"},  32'(cpp_u), 32'(m_mask[0] == 6'h3F));
      check_eq({tag, " cpp_o"},  32'(cpp_o), 32'(m_mask[1] == 6'h3F));
      check_eq({tag, " lf_u"},   32'(lf_u), 32'(m_pulse[0]));
      check_eq({tag, " lf_o"},   32'(lf_o), 32'(m_pulse[1]));
      check_eq({tag, " cnt_u"},  32'(lc_u), 32'(m_cnt[0]));
      check_eq({tag, " cnt_o"},  32'(lc_o), 32'(m_cnt[1]));
      check_eq({tag, " time_u"}, 32'(lt_u), 32'(m_time[0]));
      check_eq({tag, " time_o"}, 32'(lt_o), 32'(m_time[1]));
      check_eq({tag, " best_u"}, 32'(bl_u), 32'(m_best[0]));
      check_eq({tag, " best_o"}, 32'(bl_o), 32'(m_best[1]));
      check_eq({tag, " done_u"}, 32'(rd_u), 32'(m_done[0]));
      check_eq({tag, " done_o"}, 32'(rd_o), 32'(m_done[1]));
   endtask

   function automatic int clampc(int v);
      return (v < 0) ? 0 : ((v > 2047) ? 2047 : v);
   endfunction

   // Entered and left on a falling edge with both trackers idle.
   task automatic do_frame(input int xs, input int xe, input int ys, input int ye, input bit extra);
      bx0 = 11'(clampc(xs)); bx1 = 11'(clampc(xe));
      by0 = 11'(clampc(ys)); by1 = 11'(clampc(ye));
      frame_tick = 1'b1;
      model_tick();
      @(negedge pclk);
      frame_tick = 1'b0;
      if (extra) begin
         @(negedge pclk);
         frame_tick = 1'b1;
         model_tick();
         @(negedge pclk);
         frame_tick = 1'b0;
         repeat (5) @(negedge pclk);
      end else begin
         repeat (7) @(negedge pclk);
      end
      check_eq("early mask_u", 32'(cp_mask_u), 32'(m_mask[0]));
      check_eq("early lf_u", 32'(lf_u), 32'(0));
      @(negedge pclk);
      model_eval(clampc(xs), clampc(xe), clampc(ys), clampc(ye));
      check_all("frame");
      @(negedge pclk);
      check_eq("pulse_end_u", 32'(lf_u), 32'(0));
      check_eq("pulse_end_o", 32'(lf_o), 32'(0));
   endtask

   task automatic visit_cp(input int i);
      do_frame(rx0[i] + 2, rx1[i] - 2, ry0[i] + 2, ry1[i] - 2, 1'b0);
   endtask

   task automatic idle_frame(input bit extra);
      do_frame(0, 10, 0, 10, extra);
   endtask

   task automatic finish_frame();
      do_frame(510, 525, 10, 150, 1'b0);
   endtask

   task automatic rand_frame();
      int k, xs, xe, ys, ye;
      k = int'($urandom_range(0, 8));
      if (k <= 6) begin
         xs = rx0[k] + int'($urandom_range(0, 4)) - 1;
         xe = rx1[k] - int'($urandom_range(0, 4)) + 1;
         ys = ry0[k] + int'($urandom_range(0, 4)) - 1;
         ye = ry1[k] - int'($urandom_range(0, 4)) + 1;
      end else if (k == 7) begin
         xs = 0; xe = 10; ys = 0; ye = 10;
      end else begin
         xs = int'($urandom_range(0, 2047)); xe = int'($urandom_range(0, 2047));
         ys = int'($urandom_range(0, 2047)); ye = int'($urandom_range(0, 2047));
      end
      do_frame(xs, xe, ys, ye, ($urandom_range(0, 9) == 0));
   endtask

   task automatic do_reset();
      @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      do_reset();
      check_all("reset");

      // First checkpoint alone sets bit 0 with no lap pulse.
      visit_cp(0);
      check_eq("cp0 mask", 32'(cp_mask_u), 32'h01);

      for (int i = 1; i < 6; i++) visit_cp(i);
      for (int f = 0; f < 100; f++) idle_frame(f == 50);
      finish_frame();
      check_eq("lap1 count", 32'(lc_u), 32'd1);
      check_eq("lap1 time", 32'(lt_u), 32'd108);

      // Sitting on the finish line produces a single lap.
      idle_frame(1'b0);
      for (int i = 0; i < 6; i++) visit_cp(i);
      for (int f = 0; f < 5; f++) finish_frame();
      check_eq("hold count", 32'(lc_u), 32'd2);

      // Incomplete mask: finish entry is ignored.
      idle_frame(1'b0);
      for (int i = 0; i < 5; i++) visit_cp(i);
      finish_frame();
      check_eq("partial count", 32'(lc_u), 32'd2);
      check_eq("partial mask", 32'(cp_mask_u), 32'h1F);

      // Strict ordering: cp2 first is ignored only by the ordered tracker.
      do_reset();
      check_all("reset2");
      visit_cp(2);
      check_eq("ord cp2 first", 32'(cp_mask_o), 32'h00);
      visit_cp(0); visit_cp(1); visit_cp(2);
      check_eq("ord mask", 32'(cp_mask_o), 32'h07);

      for (int f = 0; f < 300; f++) rand_frame();

      // Full race then a fourth finish entry.
      do_reset();
      for (int l = 0; l < 3; l++) begin
         for (int i = 0; i < 6; i++) visit_cp(i);
         finish_frame();
         idle_frame(1'b0);
      end
      for (int i = 0; i < 6; i++) visit_cp(i);
      finish_frame();
      check_eq("race done", 32'(rd_u), 32'd1);
      check_eq("race count", 32'(lc_u), 32'd3);
      check_eq("race no pulse", 32'(lf_u), 32'd0);

      // Reset in the middle of a scan aborts it.
      bx0 = 11'd800; bx1 = 11'd900; by0 = 11'd195; by1 = 11'd210;
      frame_tick = 1'b1;
      @(negedge pclk);
      frame_tick = 1'b0;
      repeat (2) @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      model_reset();
      check_all("rst_scan");
      rst = 1'b0;
      repeat (12) @(negedge pclk);
      check_all("after_abort");
      visit_cp(0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
